hall_speed_detect: RTL and testbench

HALL_SPEED_DETECT -- requirements
Module: hall_speed_detect

---
 rtl/hall_speed_detect.sv | 152 +++++++++++++++
 tb/tb_hall_speed_detect.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_speed_detect.sv
// Hall-sensor front end: synchronizer, debounce filter, windowed
// rising-edge counter and edge-to-edge period meter with stall detect.
module hall_speed_detect #(
    parameter int SAMPLE_CYCLES = 10_000_000,
    parameter int FILTER_CYCLES = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 SA,
    input  logic                 enable,
    output logic                 sa_filtered,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 count_valid,
    output logic [CNT_WIDTH-1:0] period
);

    localparam int WIN_W = $clog2(SAMPLE_CYCLES);
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);

    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(SAMPLE_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LIM   = FLT_W'(FILTER_CYCLES);
    localparam logic [63:0]      STALL_LIM = 64'(2 * longint'(SAMPLE_CYCLES));

    typedef enum logic {
        IDLE,
        RUN
    } per_state_t;

    logic                 sa_meta;
    logic                 sa_sync;
    logic                 sa_q;
    logic [FLT_W-1:0]     flt_cnt;
    logic [FLT_W-1:0]     flt_nxt;
    logic                 rise;

    logic [WIN_W-1:0]     win_cnt;
    logic                 win_end;
    logic [CNT_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] acc_inc;

    per_state_t           state;
    per_state_t           state_nxt;
    logic [CNT_WIDTH-1:0] per_cnt;
    logic [CNT_WIDTH-1:0] per_cnt_nxt;
    logic [CNT_WIDTH-1:0] per_inc;
    logic [CNT_WIDTH-1:0] period_nxt;
    logic                 stall;

    assign flt_nxt = flt_cnt + FLT_W'(1);
    assign rise    = sa_filtered & ~sa_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sa_meta     <= 1'b0;
            sa_sync     <= 1'b0;
            sa_q        <= 1'b0;
            sa_filtered <= 1'b0;
            flt_cnt     <= '0;
        end else begin
            sa_meta <= SA;
            sa_sync <= sa_meta;
            sa_q    <= sa_filtered;
            if (sa_sync == sa_filtered) begin
                flt_cnt <= '0;
            end else if (flt_nxt == FLT_LIM) begin
                sa_filtered <= sa_sync;
                flt_cnt     <= '0;
            end else begin
                flt_cnt <= flt_nxt;
            end
        end
    end

    // Saturating so a fast motor pins at all-ones instead of wrapping
    assign acc_inc = (&acc) ? acc : acc + CNT_WIDTH'(1);
    assign win_end = enable && (win_cnt == WIN_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_cnt     <= '0;
            acc         <= '0;
            edge_count  <= '0;
            count_valid <= 1'b0;
        end else if (!enable) begin
            win_cnt     <= '0;
            acc         <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= win_end;
            if (win_end) begin
                win_cnt    <= '0;
                acc        <= '0;
                edge_count <= rise ? acc_inc : acc;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                if (rise) begin
                    acc <= acc_inc;
                end
            end
        end
    end

    assign per_inc = (&per_cnt) ? per_cnt : per_cnt + CNT_WIDTH'(1);
    assign stall   = (64'(per_cnt) == STALL_LIM);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            per_cnt <= '0;
            period  <= '0;
        end else begin
            state   <= state_nxt;
            per_cnt <= per_cnt_nxt;
            period  <= period_nxt;
        end
    end

    // A rise in the stall cycle restarts the measurement instead
    always_comb begin
        state_nxt   = state;
        per_cnt_nxt = per_cnt;
        period_nxt  = period;
        if (!enable) begin
            state_nxt   = IDLE;
            per_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        per_cnt_nxt = CNT_WIDTH'(1);
                        state_nxt   = RUN;
                    end
                end
                RUN: begin
                    if (rise) begin
                        period_nxt  = per_cnt;
                        per_cnt_nxt = CNT_WIDTH'(1);
                    end else if (stall) begin
                        period_nxt  = '0;
                        per_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        per_cnt_nxt = per_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hall_speed_detect.sv
// Bench for hall_speed_detect: three instances cover debounce,
// window/period timing and counter saturation.
module tb_hall_speed_detect;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic        rst_f, rst_m, rst_s;
    logic        sa_f, sa_m, sa_s;
    logic        en_f, en_m, en_s;
    logic        flt_f, flt_m, flt_s;
    logic        cv_f, cv_m, cv_s;
    logic [31:0] ec_f, ec_m, pd_f, pd_m;
    logic [3:0]  ec_s, pd_s;

    int          exp_t[$];
    logic [31:0] exp_v[$];

    hall_speed_detect #(
        .SAMPLE_CYCLES(100), .FILTER_CYCLES(4), .CNT_WIDTH(32)
    ) u_flt (
        .clk(clk), .resetn(rst_f), .SA(sa_f), .enable(en_f),
        .sa_filtered(flt_f), .edge_count(ec_f),
        .count_valid(cv_f), .period(pd_f)
    );

    hall_speed_detect #(
        .SAMPLE_CYCLES(100), .FILTER_CYCLES(1), .CNT_WIDTH(32)
    ) u_main (
        .clk(clk), .resetn(rst_m), .SA(sa_m), .enable(en_m),
        .sa_filtered(flt_m), .edge_count(ec_m),
        .count_valid(cv_m), .period(pd_m)
    );

    hall_speed_detect #(
        .SAMPLE_CYCLES(200), .FILTER_CYCLES(1), .CNT_WIDTH(4)
    ) u_sat (
        .clk(clk), .resetn(rst_s), .SA(sa_s), .enable(en_s),
        .sa_filtered(flt_s), .edge_count(ec_s),
        .count_valid(cv_s), .period(pd_s)
    );

    task automatic test_reset();
        rst_f = 1'b0; rst_m = 1'b0; rst_s = 1'b0;
        sa_f = 1'b0; sa_m = 1'b1; sa_s = 1'b0;
        en_f = 1'b0; en_m = 1'b1; en_s = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (flt_m !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_sa_filtered: got %b expected 0", flt_m);
        end
        vectors++;
        if (ec_m !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_edge_count: got %0d expected 0", ec_m);
        end
        vectors++;
        if (cv_m !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_count_valid: got %b expected 0", cv_m);
        end
        vectors++;
        if (pd_m !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_period: got %0d expected 0", pd_m);
        end
        vectors++;
        if (flt_f !== 1'b0 || cv_f !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_flt_inst: got %b/%b expected 0/0", flt_f, cv_f);
        end
        vectors++;
        if (ec_f !== 32'd0 || pd_f !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_flt_cnt: got %0d/%0d expected 0/0", ec_f, pd_f);
        end
        vectors++;
        if (ec_s !== 4'd0 || pd_s !== 4'd0) begin
            miscompares++;
            $display("FAIL rst_sat_cnt: got %0d/%0d expected 0/0", ec_s, pd_s);
        end
        vectors++;
        if (flt_s !== 1'b0 || cv_s !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_sat_flags: got %b/%b expected 0/0", flt_s, cv_s);
        end
        @(negedge clk);
        rst_f = 1'b1; rst_m = 1'b1; rst_s = 1'b1;
        sa_m = 1'b0; en_m = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_glitch();
        int hi;
        int first;
        hi = 0;
        @(negedge clk);
        sa_f = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 3) sa_f = 1'b0;
            if (flt_f) hi++;
        end
        vectors++;
        if (hi !== 0) begin
            miscompares++;
            $display("FAIL glitch_3cyc: high for %0d cycles expected 0", hi);
        end
        hi = 0;
        first = -1;
        @(negedge clk);
        sa_f = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 6) sa_f = 1'b0;
            if (flt_f) begin
                hi++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (first !== 6) begin
            miscompares++;
            $display("FAIL glitch_6cyc_start: rose at %0d expected 6", first);
        end
        vectors++;
        if (hi !== 6) begin
            miscompares++;
            $display("FAIL glitch_6cyc_len: high %0d cycles expected 6", hi);
        end
    endtask

    task automatic test_edge_period();
        int t;
        int stop_k;
        logic [31:0] v;
        exp_t.delete(); exp_v.delete();
        stop_k = -1;
        @(negedge clk);
        en_m = 1'b1;
        sa_m = 1'b1;
        exp_t.push_back(100); exp_v.push_back(32'd5);
        exp_t.push_back(200); exp_v.push_back(32'd5);
        exp_t.push_back(300); exp_v.push_back(32'd5);
        exp_t.push_back(400); exp_v.push_back(32'd1);
        exp_t.push_back(500); exp_v.push_back(32'd0);
        for (int k = 1; k <= 520; k++) begin
            @(negedge clk);
            sa_m = (k < 310) && ((k % 20) < 10);
            if (cv_m) begin
                vectors++;
                if (exp_t.size() == 0) begin
                    miscompares++;
                    $display("FAIL cnt_extra: strobe at %0d, none expected", k);
                end else begin
                    t = exp_t.pop_front();
                    v = exp_v.pop_front();
                    if (k !== t || ec_m !== v) begin
                        miscompares++;
                        $display("FAIL cnt_strobe: at %0d count %0d, expected at %0d count %0d",
                                 k, ec_m, t, v);
                    end
                end
            end
            if (k == 23) begin
                vectors++;
                if (pd_m !== 32'd0) begin
                    miscompares++;
                    $display("FAIL period_first: got %0d expected 0", pd_m);
                end
            end
            if (k == 24 || k == 450) begin
                vectors++;
                if (pd_m !== 32'd20) begin
                    miscompares++;
                    $display("FAIL period_20 at %0d: got %0d expected 20", k, pd_m);
                end
            end
            if (k > 304 && stop_k < 0 && pd_m == 32'd0) stop_k = k;
        end
        vectors++;
        if (stop_k < 0 || stop_k > 510) begin
            miscompares++;
            $display("FAIL stall: period cleared at %0d expected by 510", stop_k);
        end
        vectors++;
        if (exp_t.size() != 0) begin
            miscompares++;
            $display("FAIL cnt_missing: %0d strobes outstanding expected 0", exp_t.size());
        end
        @(negedge clk);
        en_m = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_boundary();
        int t;
        logic [31:0] v;
        exp_t.delete(); exp_v.delete();
        @(negedge clk);
        en_m = 1'b1;
        sa_m = 1'b0;
        exp_t.push_back(100); exp_v.push_back(32'd2);
        exp_t.push_back(200); exp_v.push_back(32'd0);
        for (int k = 1; k <= 210; k++) begin
            @(negedge clk);
            sa_m = (k >= 40 && k < 50) || (k >= 96 && k < 110);
            if (cv_m) begin
                vectors++;
                if (exp_t.size() == 0) begin
                    miscompares++;
                    $display("FAIL bnd_extra: strobe at %0d, none expected", k);
                end else begin
                    t = exp_t.pop_front();
                    v = exp_v.pop_front();
                    if (k !== t || ec_m !== v) begin
                        miscompares++;
                        $display("FAIL bnd_strobe: at %0d count %0d, expected at %0d count %0d",
                                 k, ec_m, t, v);
                    end
                end
            end
        end
        vectors++;
        if (exp_t.size() != 0) begin
            miscompares++;
            $display("FAIL bnd_missing: %0d strobes outstanding expected 0", exp_t.size());
        end
        @(negedge clk);
        en_m = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_enable();
        int t;
        logic [31:0] v;
        exp_t.delete(); exp_v.delete();
        @(negedge clk);
        en_m = 1'b1;
        sa_m = 1'b1;
        exp_t.push_back(100); exp_v.push_back(32'd5);
        for (int k = 1; k <= 350; k++) begin
            @(negedge clk);
            sa_m = (k % 20) < 10;
            if (k == 150) en_m = 1'b0;
            if (cv_m) begin
                vectors++;
                if (exp_t.size() == 0) begin
                    miscompares++;
                    $display("FAIL en_extra: strobe at %0d while disabled", k);
                end else begin
                    t = exp_t.pop_front();
                    v = exp_v.pop_front();
                    if (k !== t || ec_m !== v) begin
                        miscompares++;
                        $display("FAIL en_strobe: at %0d count %0d, expected at %0d count %0d",
                                 k, ec_m, t, v);
                    end
                end
            end
            if (k >= 200 && (k % 50) == 0) begin
                vectors++;
                if (ec_m !== 32'd5) begin
                    miscompares++;
                    $display("FAIL en_hold_count at %0d: got %0d expected 5", k, ec_m);
                end
                vectors++;
                if (pd_m !== 32'd20) begin
                    miscompares++;
                    $display("FAIL en_hold_period at %0d: got %0d expected 20", k, pd_m);
                end
            end
        end
        vectors++;
        if (exp_t.size() != 0) begin
            miscompares++;
            $display("FAIL en_missing: %0d strobes outstanding expected 0", exp_t.size());
        end
    endtask

    task automatic test_reset_mid();
        int t;
        logic [31:0] v;
        exp_t.delete(); exp_v.delete();
        @(negedge clk);
        en_m = 1'b1;
        sa_m = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            sa_m = (k % 20) < 10;
            if (k == 50) begin
                rst_m = 1'b0;
                #1;
                vectors++;
                if (ec_m !== 32'd0 || pd_m !== 32'd0) begin
                    miscompares++;
                    $display("FAIL mid_rst_counts: got %0d/%0d expected 0/0", ec_m, pd_m);
                end
                vectors++;
                if (cv_m !== 1'b0 || flt_m !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mid_rst_flags: got %b/%b expected 0/0", cv_m, flt_m);
                end
            end
            if (k == 53) begin
                rst_m = 1'b1;
                exp_t.push_back(k + 100); exp_v.push_back(32'd5);
                exp_t.push_back(k + 200); exp_v.push_back(32'd5);
            end
            if (cv_m) begin
                vectors++;
                if (exp_t.size() == 0) begin
                    miscompares++;
                    $display("FAIL mid_extra: strobe at %0d, none expected", k);
                end else begin
                    t = exp_t.pop_front();
                    v = exp_v.pop_front();
                    if (k !== t || ec_m !== v) begin
                        miscompares++;
                        $display("FAIL mid_strobe: at %0d count %0d, expected at %0d count %0d",
                                 k, ec_m, t, v);
                    end
                end
            end
        end
        vectors++;
        if (exp_t.size() != 0) begin
            miscompares++;
            $display("FAIL mid_missing: %0d strobes outstanding expected 0", exp_t.size());
        end
        @(negedge clk);
        en_m = 1'b0;
    endtask

    task automatic test_saturation();
        int t;
        logic [31:0] v;
        exp_t.delete(); exp_v.delete();
        @(negedge clk);
        en_s = 1'b1;
        sa_s = 1'b1;
        exp_t.push_back(200); exp_v.push_back(32'd15);
        exp_t.push_back(400); exp_v.push_back(32'd15);
        for (int k = 1; k <= 410; k++) begin
            @(negedge clk);
            sa_s = (k % 8) < 4;
            if (cv_s) begin
                vectors++;
                if (exp_t.size() == 0) begin
                    miscompares++;
                    $display("FAIL sat_extra: strobe at %0d, none expected", k);
                end else begin
                    t = exp_t.pop_front();
                    v = exp_v.pop_front();
                    if (k !== t || {28'd0, ec_s} !== v) begin
                        miscompares++;
                        $display("FAIL sat_strobe: at %0d count %0d, expected at %0d count %0d",
                                 k, ec_s, t, v);
                    end
                end
            end
            if (k == 400) begin
                vectors++;
                if (pd_s !== 4'd8) begin
                    miscompares++;
                    $display("FAIL sat_period: got %0d expected 8", pd_s);
                end
            end
        end
        vectors++;
        if (exp_t.size() != 0) begin
            miscompares++;
            $display("FAIL sat_missing: %0d strobes outstanding expected 0", exp_t.size());
        end
        @(negedge clk);
        en_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_edge_period();
        test_boundary();
        test_enable();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
